// File: rtl/mult4_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult4_seq_ctrl
//   Sequential 4x4 unsigned multiplier. It uses one 4-bit add per cycle with
//   the carry kept. A multiply walks IDLE -> CALC (4 cycles) -> DONE -> IDLE,
//   so a held start gives one result every 6 cycles.
//
//   Optional feature: define MULT4_ZERO_SKIP_EN. A start with a zero operand
//   then goes straight IDLE -> DONE with product 8'h00, and busy stays low.
//
// Ports
//   i_clk      rising-edge clock
//   i_rst_n    asynchronous active-low reset
//   i_start    request a multiply; only accepted while o_ready is high
//   i_a, i_b   4-bit unsigned operands, captured on the accepting edge
//   o_ready    high only in IDLE
//   o_busy     high in CALC
//   o_done     one-cycle pulse; o_product is valid during it
//   o_product  8-bit result; holds until the next result is produced
// ---------------------------------------------------------------------------
module mult4_seq_ctrl (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_mcand;
    logic [3:0] r_mq;
    // The accumulator is architecturally 5 bits wide. After every
    // right-shift its top bit is 0, so only the low 4 bits are stored.
    logic [3:0] r_acc;
    logic [1:0] r_cnt;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_product;

    logic [4:0] w_sum;
    logic       w_zero;

    // One shift-add step. The carry lands in w_sum[4] and is shifted back
    // into the accumulator, so 15*15 cannot overflow.
    assign w_sum = r_mq[0] ? ({1'b0, r_acc} + {1'b0, r_mcand}) : {1'b0, r_acc};

`ifdef MULT4_ZERO_SKIP_EN
    assign w_zero = (i_a == 4'd0) || (i_b == 4'd0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_mcand   <= 4'd0;
            r_mq      <= 4'd0;
            r_acc     <= 4'd0;
            r_cnt     <= 2'd0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mcand <= i_a;
                        r_mq    <= i_b;
                        r_acc   <= 4'd0;
                        r_cnt   <= 2'd0;
                        r_ready <= 1'b0;
                        if (w_zero) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_product <= 8'h00;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    // {acc,mq} <= {sum,mq} >> 1
                    r_acc <= w_sum[4:1];
                    r_mq  <= {w_sum[0], r_mq[3:1]};
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        // Publish the post-shift value directly, so the
                        // result is visible in the first DONE cycle.
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_product <= {w_sum, r_mq[3:1]};
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready   = r_ready;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_product;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult4_seq_ctrl
//   Scoreboard bench. Each accepted start pushes a*b onto a queue. A monitor
//   pops an entry and compares it with o_product on every done pulse.
// ---------------------------------------------------------------------------
module tb_mult4_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] ia;
    logic [3:0] ib;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int q[$];
    int done_cyc[$];

    mult4_seq_ctrl dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_a       (ia),
        .i_b       (ib),
        .o_ready   (ready),
        .o_busy    (busy),
        .o_done    (done),
        .o_product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Monitor: each done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (done) begin
            done_cyc.push_back(cyc);
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else               chk("product", int'(product), q.pop_front());
        end
    end

    // Runs one isolated multiply. It checks latency, the number of busy
    // cycles, pulse width and product hold. Operands are scrambled after
    // acceptance to prove they are captured.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b);
        int lat, nbusy, exp_lat, exp_busy;
        exp_lat = 5; exp_busy = 4;
`ifdef MULT4_ZERO_SKIP_EN
        if (a == 4'd0 || b == 4'd0) begin exp_lat = 1; exp_busy = 0; end
`endif
        @(negedge clk);
        chk("ready_before", int'(ready), 1);
        start = 1'b1; ia = a; ib = b;
        @(posedge clk);
        q.push_back(int'(a) * int'(b));
        @(negedge clk);
        start = 1'b0;
        ia = 4'($urandom_range(15));
        ib = 4'($urandom_range(15));
        lat = 1; nbusy = 0;
        while (!done && lat < 20) begin
            nbusy += int'(busy);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("busy_cycles", nbusy, exp_busy);
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("ready_after", int'(ready), 1);
        chk("product_hold", int'(product), int'(a) * int'(b));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] pa[3];
        logic [3:0] pb[3];
        int w;
        pa[0] = 4'd3;  pb[0] = 4'd5;
        pa[1] = 4'd15; pb[1] = 4'd1;
        pa[2] = 4'd8;  pb[2] = 4'd8;

        rst_n = 1'b0; start = 1'b0; ia = 4'd0; ib = 4'd0;
        #12;
        chk("rst_ready",   int'(ready), 1);
        chk("rst_busy",    int'(busy), 0);
        chk("rst_done",    int'(done), 0);
        chk("rst_product", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Max operands, then a zero operand
        run_op(4'hF, 4'hF);
        run_op(4'h9, 4'h0);

        // A start pulse during CALC must be ignored
        @(negedge clk);
        start = 1'b1; ia = 4'h6; ib = 4'h7;
        @(posedge clk);
        q.push_back(42);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; ia = 4'h2; ib = 4'h2;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignored_start_q", q.size(), 0);
        chk("ignored_product", int'(product), 42);

        // Reset in the second CALC cycle aborts the operation
        @(negedge clk);
        start = 1'b1; ia = 4'hD; ib = 4'hB;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready",   int'(ready), 1);
        chk("abort_busy",    int'(busy), 0);
        chk("abort_done",    int'(done), 0);
        chk("abort_product", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", q.size(), 0);

        // Back-to-back with start held high; accepted on the first edge after reset release
        rst_n = 1'b0;
        @(negedge clk);
        done_cyc.delete();
        rst_n = 1'b1; start = 1'b1; ia = pa[0]; ib = pb[0];
        @(posedge clk);
        q.push_back(int'(pa[0]) * int'(pb[0]));
        #1;
        chk("first_accept", int'(busy), 1);
        for (int i = 1; i < 3; i++) begin
            w = 0;
            @(negedge clk);
            while (!ready && w < 20) begin @(negedge clk); w++; end
            ia = pa[i]; ib = pb[i];
            @(posedge clk);
            q.push_back(int'(pa[i]) * int'(pb[i]));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_q", q.size(), 0);
        chk("b2b_count", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            chk("b2b_gap0", done_cyc[1] - done_cyc[0], 6);
            chk("b2b_gap1", done_cyc[2] - done_cyc[1], 6);
        end

        // Exhaustive sweep
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run_op(4'(x), 4'(y));

        repeat (4) @(negedge clk);
        chk("final_q", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
